raster_frame_scheduler: RTL and testbench

Frame-level controller for the rasterizer. It queues triangle commands from the MicroBlaze and, on each frame, clears the framebuffer and z-buffer. It then dispatches queued triangles to the rasterizer one at a time using its start/done handshake, and finally flips the display buffer select. It also owns the framebuffer and z-buffer write ports, muxing between its clear engine and the rasterizer.

---
 rtl/raster_pkg.sv | 41 ++++
 rtl/tri_cmd_fifo.sv | 55 +++++
 rtl/raster_frame_scheduler.sv | 139 +++++++++++++
 tb/tb_raster_frame_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared types and constants for the raster frame scheduler: the packed
// triangle command, screen geometry and the scheduler state encoding.
package raster_pkg;

    localparam int         SCREEN_W   = 320;
    localparam int         SCREEN_H   = 240;
    localparam int         FB_WORDS   = SCREEN_W * SCREEN_H;
    localparam logic [7:0] ZBUF_CLEAR = 8'hFF;

    // Field order is MSB to LSB; the rasterizer consumes this layout bit-for-bit.
    typedef struct packed {
        logic        [31:0] inv_area;
        logic        [7:0]  color;
        logic signed [9:0]  a1;
        logic signed [9:0]  b1;
        logic signed [9:0]  a2;
        logic signed [9:0]  b2;
        logic signed [9:0]  a3;
        logic signed [9:0]  b3;
        logic signed [17:0] c1;
        logic signed [17:0] c2;
        logic signed [17:0] c3;
        logic        [8:0]  bbxi;
        logic        [8:0]  bbxf;
        logic        [7:0]  bbyi;
        logic        [7:0]  bbyf;
        logic        [15:0] z1;
        logic        [15:0] z2;
        logic        [15:0] z3;
    } tri_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_START,
        S_BUSY,
        S_SWAP
    } state_t;

endpackage

// File: rtl/tri_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO of triangle commands.
// Pushes while full and pops while empty are ignored.
module tri_cmd_fifo
    import raster_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  tri_cmd_t               din,
    output tri_cmd_t               dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

    tri_cmd_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/raster_frame_scheduler.sv
// Frame controller: clears frame/z buffers, dispatches queued triangles to the
// rasterizer one at a time, then flips the display buffer.
module raster_frame_scheduler
    import raster_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int FB_WORDS = raster_pkg::FB_WORDS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tri_valid,
    input  tri_cmd_t               tri_data,
    output logic                   tri_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    input  logic                   frame_begin,
    input  logic                   frame_end,
    input  logic [7:0]             bg_color,
    output logic                   frame_done,
    output logic                   fb_sel,
    output logic                   busy,
    output logic                   rast_start,
    output tri_cmd_t               rast_cmd,
    input  logic                   rast_done,
    input  logic                   r_we,
    input  logic [7:0]             r_din,
    input  logic [16:0]            r_addr,
    input  logic [16:0]            r_zaddr,
    input  logic [7:0]             r_zdin,
    input  logic                   r_zwe,
    input  logic                   r_zen,
    output logic                   fb_we,
    output logic [7:0]             fb_din,
    output logic [16:0]            fb_addr,
    output logic [16:0]            zb_addr,
    output logic [7:0]             zb_din,
    output logic                   zb_we,
    output logic                   zb_en
);

    localparam logic [16:0] CLR_LAST = 17'(FB_WORDS - 1);

    state_t      state;
    logic [7:0]  bg;
    logic [16:0] clr_addr;
    logic        end_pending;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    tri_cmd_t    fifo_head;

    assign tri_ready = !fifo_full;
    assign busy      = (state != S_IDLE);
    assign fifo_pop  = (state == S_FETCH) && !fifo_empty;

    tri_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tri_valid),
        .pop   (fifo_pop),
        .din   (tri_data),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            bg          <= '0;
            clr_addr    <= '0;
            end_pending <= 1'b0;
            rast_cmd    <= '0;
            rast_start  <= 1'b0;
            frame_done  <= 1'b0;
            fb_sel      <= 1'b0;
        end else begin
            rast_start <= 1'b0;
            frame_done <= 1'b0;
            if (frame_end && state != S_IDLE) end_pending <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (frame_begin) begin
                        bg       <= bg_color;
                        clr_addr <= '0;
                        state    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == CLR_LAST) state <= S_FETCH;
                end
                S_FETCH: begin
                    // Pulses are raised on entry so they appear in START/SWAP themselves.
                    if (!fifo_empty) begin
                        rast_cmd   <= fifo_head;
                        rast_start <= 1'b1;
                        state      <= S_START;
                    end else if (end_pending) begin
                        fb_sel     <= !fb_sel;
                        frame_done <= 1'b1;
                        state      <= S_SWAP;
                    end
                end
                S_START: state <= S_BUSY;
                S_BUSY: begin
                    if (rast_done) state <= S_FETCH;
                end
                S_SWAP: begin
                    end_pending <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: pass-through defaults first, so every output is assigned on every path and no latch is inferred.
        fb_we   = r_we;
        fb_din  = r_din;
        fb_addr = r_addr;
        zb_addr = r_zaddr;
        zb_din  = r_zdin;
        zb_we   = r_zwe;
        zb_en   = r_zen;
        if (state == S_CLEAR) begin
            fb_we   = 1'b1;
            fb_din  = bg;
            fb_addr = clr_addr;
            zb_addr = clr_addr;
            zb_din  = ZBUF_CLEAR;
            zb_we   = 1'b1;
            zb_en   = 1'b1;
        end
    end

endmodule

// File: tb/tb_raster_frame_scheduler.sv
// Directed bench for raster_frame_scheduler; inputs change and outputs are
// sampled on the falling clock edge.
module tb_raster_frame_scheduler;

    localparam int DEPTH = 8;
    // Reduced buffer size keeps each frame short; the clear logic is size-agnostic.
    localparam int FB_W  = 1200;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tri_valid = 1'b0;
    logic [235:0] tri_data = '0;
    logic         tri_ready;
    logic [3:0]   fifo_count;
    logic         frame_begin = 1'b0;
    logic         frame_end = 1'b0;
    logic [7:0]   bg_color = '0;
    logic         frame_done;
    logic         fb_sel;
    logic         busy;
    logic         rast_start;
    logic [235:0] rast_cmd;
    logic         rast_done = 1'b0;
    logic         r_we = 1'b0;
    logic [7:0]   r_din = '0;
    logic [16:0]  r_addr = '0;
    logic [16:0]  r_zaddr = '0;
    logic [7:0]   r_zdin = '0;
    logic         r_zwe = 1'b0;
    logic         r_zen = 1'b0;
    logic         fb_we;
    logic [7:0]   fb_din;
    logic [16:0]  fb_addr;
    logic [16:0]  zb_addr;
    logic [7:0]   zb_din;
    logic         zb_we;
    logic         zb_en;

    int errors = 0;
    int checks = 0;

    raster_frame_scheduler #(.DEPTH(DEPTH), .FB_WORDS(FB_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tri_valid   (tri_valid),
        .tri_data    (tri_data),
        .tri_ready   (tri_ready),
        .fifo_count  (fifo_count),
        .frame_begin (frame_begin),
        .frame_end   (frame_end),
        .bg_color    (bg_color),
        .frame_done  (frame_done),
        .fb_sel      (fb_sel),
        .busy        (busy),
        .rast_start  (rast_start),
        .rast_cmd    (rast_cmd),
        .rast_done   (rast_done),
        .r_we        (r_we),
        .r_din       (r_din),
        .r_addr      (r_addr),
        .r_zaddr     (r_zaddr),
        .r_zdin      (r_zdin),
        .r_zwe       (r_zwe),
        .r_zen       (r_zen),
        .fb_we       (fb_we),
        .fb_din      (fb_din),
        .fb_addr     (fb_addr),
        .zb_addr     (zb_addr),
        .zb_din      (zb_din),
        .zb_we       (zb_we),
        .zb_en       (zb_en)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    function automatic logic [235:0] make_tri(input int k);
        logic [255:0] w;
        w = {8{(32'(k) * 32'h9E3779B1) ^ 32'hC0DE0000}};
        return w[235:0];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tri_valid = 1'b0; frame_begin = 1'b0; frame_end = 1'b0; rast_done = 1'b0;
        r_we = 1'b0; r_zwe = 1'b0; r_zen = 1'b0; r_addr = '0; r_zaddr = '0; r_din = '0; r_zdin = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_frame_begin(input logic [7:0] color);
        bg_color = color;
        frame_begin = 1'b1;
        @(negedge clk);
        frame_begin = 1'b0;
    endtask

    // Returns at the negedge showing the final clear write (address FB_W-1).
    task automatic wait_last_clear(input string tag);
        bit found = 0;
        for (int i = 0; i < FB_W + 20; i++) begin
            if (fb_we === 1'b1 && fb_addr === 17'(FB_W - 1)) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s_last_clear: got no final clear write, expected addr %0d", tag, FB_W - 1);
        end
    endtask

    // Called at the negedge where rast_start should be high; returns two cycles after rast_done.
    task automatic serve_tri(input logic [235:0] exp, input int delay, input string tag);
        checks++;
        if (rast_start !== 1'b1) begin
            errors++; $display("FAIL %s_start: got %0b expected 1", tag, rast_start);
        end
        checks++;
        if (rast_cmd !== exp) begin
            errors++; $display("FAIL %s_cmd: got %h expected %h", tag, rast_cmd, exp);
        end
        @(negedge clk);
        checks++;
        if (rast_start !== 1'b0) begin
            errors++; $display("FAIL %s_start_width: got %0b expected 0", tag, rast_start);
        end
        repeat (delay - 1) @(negedge clk);
        checks++;
        if (rast_cmd !== exp) begin
            errors++; $display("FAIL %s_cmd_stable: got %h expected %h", tag, rast_cmd, exp);
        end
        rast_done = 1'b1;
        @(negedge clk);
        rast_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        if (tri_ready !== 1'b1)  begin errors++; $display("FAIL reset_tri_ready: got %0b expected 1", tri_ready); end
        if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        if ({frame_done, fb_sel, busy, rast_start} !== 4'b0000)
            begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {frame_done, fb_sel, busy, rast_start}); end
        if (rast_cmd !== '0) begin errors++; $display("FAIL reset_rast_cmd: got %h expected 0", rast_cmd); end
        if ({fb_we, zb_we, zb_en} !== 3'b000)
            begin errors++; $display("FAIL reset_mem_we: got %b expected 000", {fb_we, zb_we, zb_en}); end
        checks += 5;
    endtask

    task automatic test_clear();
        int bad = 0;
        int starts = 0;
        bit seen = 0;
        do_reset();
        pulse_frame_begin(8'h03);
        for (int i = 0; i < FB_W; i++) begin
            if (fb_we !== 1'b1 || zb_we !== 1'b1 || zb_en !== 1'b1 || fb_addr !== 17'(i) ||
                zb_addr !== 17'(i) || fb_din !== 8'h03 || zb_din !== 8'hFF) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL clear_writes: got %0d bad cycles expected 0", bad); end
        checks++;
        if (fb_we !== 1'b0 || zb_we !== 1'b0) begin
            errors++; $display("FAIL clear_stop: got fb_we=%0b zb_we=%0b expected 0", fb_we, zb_we);
        end
        for (int i = 0; i < 10; i++) begin
            if (rast_start === 1'b1) starts++;
            @(negedge clk);
        end
        checks++;
        if (starts != 0 || busy !== 1'b1) begin
            errors++; $display("FAIL clear_empty_fetch: got starts=%0d busy=%0b expected 0/1", starts, busy);
        end
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (frame_done === 1'b1) begin seen = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen || fb_sel !== 1'b1) begin
            errors++; $display("FAIL clear_frame_done: got done=%0b fb_sel=%0b expected 1/1", seen, fb_sel);
        end
    endtask

    task automatic test_two_triangles();
        do_reset();
        pulse_frame_begin(8'h20);
        tri_valid = 1'b1; tri_data = make_tri(1);
        @(negedge clk);
        tri_data = make_tri(2);
        @(negedge clk);
        tri_valid = 1'b0; frame_end = 1'b1;
        checks++;
        if (fifo_count !== 4'd2) begin errors++; $display("FAIL two_preload_count: got %0d expected 2", fifo_count); end
        @(negedge clk);
        frame_end = 1'b0;
        wait_last_clear("two");
        @(negedge clk);
        checks++;
        if (rast_start !== 1'b0) begin errors++; $display("FAIL two_early_start: got %0b expected 0", rast_start); end
        @(negedge clk);
        serve_tri(make_tri(1), 50, "two_t0");
        serve_tri(make_tri(2), 50, "two_t1");
        checks++;
        if (frame_done !== 1'b1 || fb_sel !== 1'b1 || rast_start !== 1'b0) begin
            errors++; $display("FAIL two_swap: got done=%0b fb_sel=%0b start=%0b expected 1/1/0", frame_done, fb_sel, rast_start);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL two_idle: got done=%0b busy=%0b expected 0/0", frame_done, busy);
        end
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (tri_ready !== logic'(i < DEPTH)) begin
                errors++; $display("FAIL full_ready_%0d: got %0b expected %0b", i, tri_ready, i < DEPTH);
            end
            tri_valid = 1'b1; tri_data = make_tri(100 + i);
            @(negedge clk);
        end
        tri_valid = 1'b0;
        checks++;
        if (fifo_count !== 4'd8 || tri_ready !== 1'b0) begin
            errors++; $display("FAIL full_count: got count=%0d ready=%0b expected 8/0", fifo_count, tri_ready);
        end
        pulse_frame_begin(8'h00);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        wait_last_clear("full");
        @(negedge clk);
        // First FETCH with the FIFO full: a concurrent push must still be refused.
        checks++;
        if (tri_ready !== 1'b0) begin errors++; $display("FAIL full_ready_at_pop: got %0b expected 0", tri_ready); end
        tri_valid = 1'b1; tri_data = make_tri(999);
        @(negedge clk);
        tri_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) serve_tri(make_tri(100 + i), 3, "full_drain");
        checks++;
        if (frame_done !== 1'b1 || fifo_count !== 4'd0) begin
            errors++; $display("FAIL full_no_extra: got done=%0b count=%0d expected 1/0", frame_done, fifo_count);
        end
    endtask

    task automatic test_end_in_clear();
        do_reset();
        pulse_frame_begin(8'h55);
        repeat (5) @(negedge clk);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        wait_last_clear("endclr");
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL endclr_early: got %0b expected 0", frame_done); end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1 || fb_sel !== 1'b1) begin
            errors++; $display("FAIL endclr_done: got done=%0b fb_sel=%0b expected 1/1", frame_done, fb_sel);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL endclr_pulse: got done=%0b busy=%0b expected 0/0", frame_done, busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        bit hit = 0;
        int writes = 0;
        do_reset();
        pulse_frame_begin(8'h9C);
        for (int i = 0; i < 1100; i++) begin
            if (fb_addr === 17'd1000 && fb_we === 1'b1) begin hit = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL midrst_reach: got no write at 1000 expected one"); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fb_we, zb_we, busy} !== 3'b000) begin
            errors++; $display("FAIL midrst_abort: got fb_we/zb_we/busy=%b expected 000", {fb_we, zb_we, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fb_we !== 1'b0 || zb_we !== 1'b0 || busy !== 1'b0) writes++;
        end
        checks++;
        if (writes != 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", writes); end
    endtask

    task automatic test_busy_passthrough();
        do_reset();
        tri_valid = 1'b1; tri_data = make_tri(7);
        @(negedge clk);
        tri_valid = 1'b0;
        pulse_frame_begin(8'h11);
        wait_last_clear("busy");
        repeat (2) @(negedge clk);
        checks++;
        if (rast_start !== 1'b1) begin errors++; $display("FAIL busy_start: got %0b expected 1", rast_start); end
        @(negedge clk);
        r_we = 1'b1; r_addr = 17'h00100; r_din = 8'h5A;
        r_zwe = 1'b1; r_zen = 1'b1; r_zaddr = 17'h00200; r_zdin = 8'h33;
        #1;
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== 17'h00100 || fb_din !== 8'h5A) begin
            errors++; $display("FAIL busy_fb_pass: got we=%0b addr=%h din=%h expected 1/00100/5a", fb_we, fb_addr, fb_din);
        end
        checks++;
        if (zb_we !== 1'b1 || zb_en !== 1'b1 || zb_addr !== 17'h00200 || zb_din !== 8'h33) begin
            errors++; $display("FAIL busy_zb_pass: got we=%0b en=%0b addr=%h din=%h expected 1/1/00200/33", zb_we, zb_en, zb_addr, zb_din);
        end
        @(negedge clk);
        r_we = 1'b0; r_zwe = 1'b0; r_zen = 1'b0;
        pulse_frame_begin(8'h77);
        checks++;
        if (busy !== 1'b1 || fb_we !== 1'b0 || rast_start !== 1'b0) begin
            errors++; $display("FAIL busy_ignore_begin: got busy=%0b fb_we=%0b start=%0b expected 1/0/0", busy, fb_we, rast_start);
        end
        rast_done = 1'b1;
        @(negedge clk);
        rast_done = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || rast_start !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL busy_fetch_wait: got busy=%0b start=%0b done=%0b expected 1/0/0", busy, rast_start, frame_done);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_two_triangles();
        test_fifo_full();
        test_end_in_clear();
        test_reset_mid_clear();
        test_busy_passthrough();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
